fetch_control_unit: RTL and testbench

//  Decode-side partner of the program memory / PC fetch stage. Consumes ins/current_address and

---
 rtl/fcu_pkg.sv | 49 ++++
 rtl/fcu_hazard_detect.sv | 38 +++
 rtl/fetch_control_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_control_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcu_pkg.sv
// fcu_pkg: opcode map, instruction field helpers and FSM state encoding
// shared by the fetch control unit and its hazard detector.
package fcu_pkg;

   localparam int unsigned FCU_ADDR_W = 16;
   localparam int unsigned FCU_INS_W  = 32;
   localparam logic [31:0] FCU_NOP_INS = 32'h0000_0000;

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_LD  = 6'h10;
   localparam logic [5:0] OP_ST  = 6'h11;
   localparam logic [5:0] OP_JMP = 6'h20;
   localparam logic [5:0] OP_BZ  = 6'h21;
   localparam logic [5:0] OP_BNZ = 6'h22;
   localparam logic [5:0] OP_HLT = 6'h3F;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_LDSTALL = 2'd2,
      ST_HALT    = 2'd3
   } fcu_state_e;

   function automatic logic [5:0] insOp(input logic [31:0] ins);
      return ins[31:26];
   endfunction

   function automatic logic [4:0] insRd(input logic [31:0] ins);
      return ins[25:21];
   endfunction

   function automatic logic [4:0] insRs1(input logic [31:0] ins);
      return ins[20:16];
   endfunction

   function automatic logic [4:0] insRs2(input logic [31:0] ins);
      return ins[15:11];
   endfunction

   function automatic logic [15:0] insImm(input logic [31:0] ins);
      return ins[15:0];
   endfunction

   // ALU class occupies the whole 6'h00..6'h0F opcode block (NOP included)
   function automatic logic isAluOp(input logic [5:0] op);
      return (op[5:4] == 2'b00);
   endfunction

endpackage

// File: rtl/fcu_hazard_detect.sv
// fcu_hazard_detect: flags a load-use hazard when the instruction on the
// fetch output reads the destination of the load issued just before it.
module fcu_hazard_detect
   import fcu_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [4:0] rd_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic       ld_pend_i,
   input  logic [4:0] ld_rd_i,
   output logic       load_use_o
);

   logic       useRs1;
   logic       useSrcB;
   logic [4:0] srcB;

   // Decide which register fields the opcode really reads; r0 never creates a hazard
   always_comb begin
      useRs1  = 1'b0;
      useSrcB = 1'b0;
      srcB    = rs2_i;
      if (isAluOp(op_i)) begin
         useRs1  = 1'b1;
         useSrcB = 1'b1;
      end else if (op_i == OP_LD) begin
         useRs1  = 1'b1;
      end else if (op_i == OP_ST) begin
         useRs1  = 1'b1;
         useSrcB = 1'b1;
         srcB    = rd_i;
      end
      load_use_o = ld_pend_i && (ld_rd_i != 5'd0) &&
                   ((useRs1 && (rs1_i == ld_rd_i)) || (useSrcB && (srcB == ld_rd_i)));
   end

endmodule

// File: rtl/fetch_control_unit.sv
// fetch_control_unit: decode-side controller for the PC / program memory
// stage. Resolves jumps and branches, squashes the single wrong-path slot,
// inserts load-use bubbles, halts on HLT and registers the surviving
// instruction into the decode pipeline register.
module fetch_control_unit
   import fcu_pkg::*;
#(
   parameter int unsigned          ADDR_W  = FCU_ADDR_W,
   parameter int unsigned          INS_W   = FCU_INS_W,
   parameter logic [INS_W-1:0]     NOP_INS = INS_W'(FCU_NOP_INS)
)(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [INS_W-1:0]  ins_i,
   input  logic [ADDR_W-1:0] current_address_i,
   input  logic              zero_flag_i,
   output logic [ADDR_W-1:0] jmp_loc_o,
   output logic              pc_mux_sel_o,
   output logic              stall_o,
   output logic              stall_pm_o,
   output logic [INS_W-1:0]  dec_ins_o,
   output logic [ADDR_W-1:0] dec_pc_o,
   output logic              dec_valid_o,
   output logic              halted_o
);

   fcu_state_e        state_q;
   fcu_state_e        state_d;
   logic              ld_pend_q;
   logic [4:0]        ld_rd_q;
   logic [INS_W-1:0]  dec_ins_q;
   logic [ADDR_W-1:0] dec_pc_q;
   logic              dec_valid_q;
   logic              halted_q;

   logic [31:0] insWord;
   logic [5:0]  op;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic        loadUse;
   logic        takenJump;
   logic        isHlt;
   logic        issue;
   logic        redirect;
   logic        holdFetch;

   assign insWord = ins_i[31:0];
   assign op      = insOp(insWord);
   assign rd      = insRd(insWord);
   assign imm     = insImm(insWord);

   fcu_hazard_detect u_hazard (
      .op_i       (op),
      .rd_i       (rd),
      .rs1_i      (insRs1(insWord)),
      .rs2_i      (insRs2(insWord)),
      .ld_pend_i  (ld_pend_q),
      .ld_rd_i    (ld_rd_q),
      .load_use_o (loadUse)
   );

   // Next-state and control decode: load-use beats HLT, HLT beats a redirect
   always_comb begin
      takenJump = (op == OP_JMP) ||
                  ((op == OP_BZ)  &&  zero_flag_i) ||
                  ((op == OP_BNZ) && !zero_flag_i);
      isHlt     = (op == OP_HLT);
      state_d   = state_q;
      issue     = 1'b0;
      redirect  = 1'b0;
      holdFetch = 1'b0;
      unique case (state_q)
         ST_RUN, ST_LDSTALL: begin
            if ((state_q == ST_RUN) && loadUse) begin
               holdFetch = 1'b1;
               state_d   = ST_LDSTALL;
            end else if (isHlt) begin
               issue     = 1'b1;
               holdFetch = 1'b1;
               state_d   = ST_HALT;
            end else if (takenJump) begin
               issue     = 1'b1;
               redirect  = 1'b1;
               state_d   = ST_FLUSH;
            end else begin
               issue     = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         ST_HALT: begin
            holdFetch = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Control outputs are forced quiet while reset is held so the PC stage sees PC+1, no stall
   assign pc_mux_sel_o = rst_ni & redirect;
   assign stall_o      = rst_ni & holdFetch;
   assign stall_pm_o   = rst_ni & holdFetch;
   assign jmp_loc_o    = (rst_ni && redirect) ? ADDR_W'(imm) : '0;

   // State, load tracking and the decode pipeline register; non-issuing cycles emit a bubble
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         ld_pend_q   <= 1'b0;
         ld_rd_q     <= 5'd0;
         dec_ins_q   <= NOP_INS;
         dec_pc_q    <= '0;
         dec_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == ST_HALT) begin
            halted_q <= 1'b1;
         end
         if (issue) begin
            dec_ins_q   <= ins_i;
            dec_pc_q    <= current_address_i;
            dec_valid_q <= 1'b1;
            ld_pend_q   <= (op == OP_LD);
            if (op == OP_LD) begin
               ld_rd_q <= rd;
            end
         end else begin
            dec_ins_q   <= NOP_INS;
            dec_valid_q <= 1'b0;
            ld_pend_q   <= 1'b0;
         end
      end
   end

   assign dec_ins_o   = dec_ins_q;
   assign dec_pc_o    = dec_pc_q;
   assign dec_valid_o = dec_valid_q;
   assign halted_o    = halted_q;

endmodule

// File: tb/tb_fetch_control_unit.sv
// tb_fetch_control_unit: directed scenarios for each control rule, then
// random programs run through a small fetch-stage model and compared with
// an instruction-level trace of what should retire and how many bubbles
// should precede each retired instruction.
module tb_fetch_control_unit;

   localparam int MAX_TR  = 150;
   localparam int CYC_MAX = 1500;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ins;
   logic [15:0] curAddr;
   logic        zeroFlag;
   logic [15:0] jmpLoc;
   logic        pcSel;
   logic        stall;
   logic        stallPm;
   logic [31:0] decIns;
   logic [15:0] decPc;
   logic        decValid;
   logic        halted;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] mem [64];
   logic        zf  [64];
   logic [31:0] trIns [MAX_TR];
   logic [15:0] trPc  [MAX_TR];
   int          trBub [MAX_TR];
   int          trLen;

   always #5 clk = ~clk;

   fetch_control_unit dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .ins_i             (ins),
      .current_address_i (curAddr),
      .zero_flag_i       (zeroFlag),
      .jmp_loc_o         (jmpLoc),
      .pc_mux_sel_o      (pcSel),
      .stall_o           (stall),
      .stall_pm_o        (stallPm),
      .dec_ins_o         (decIns),
      .dec_pc_o          (decPc),
      .dec_valid_o       (decValid),
      .halted_o          (halted)
   );

   function automatic logic [31:0] mkR(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2, 11'h000};
   endfunction

   function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   // True when instruction w reads register r as a source operand
   function automatic bit readsReg(input logic [31:0] w, input logic [4:0] r);
      logic [5:0] op;
      op = w[31:26];
      if (op[5:4] == 2'b00) return (w[20:16] == r) || (w[15:11] == r);
      if (op == 6'h10)      return (w[20:16] == r);
      if (op == 6'h11)      return (w[20:16] == r) || (w[25:21] == r);
      return 1'b0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Present one fetch-stage word just after the edge, then wait for the sampling point
   task automatic applyStimulus(input logic [31:0] insVal, input logic [15:0] addrVal, input logic zfVal);
      @(posedge clk);
      #1;
      ins      = insVal;
      curAddr  = addrVal;
      zeroFlag = zfVal;
      @(negedge clk);
   endtask

   task automatic genProgram();
      int r;
      logic [4:0]  rd, rs1, rs2;
      logic [15:0] tgt;
      for (int i = 0; i < 64; i++) begin
         r   = int'($urandom_range(0, 99));
         rd  = 5'($urandom_range(0, 7));
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         tgt = 16'($urandom_range(0, 63));
         if (r < 25)      mem[i] = mkR(6'($urandom_range(0, 15)), rd, rs1, rs2);
         else if (r < 45) mem[i] = mkI(6'h10, rd, rs1, 16'($urandom));
         else if (r < 55) mem[i] = mkR(6'h11, rd, rs1, rs2);
         else if (r < 63) mem[i] = mkI(6'h20, rd, rs1, tgt);
         else if (r < 71) mem[i] = mkI(6'h21, rd, rs1, tgt);
         else if (r < 79) mem[i] = mkI(6'h22, rd, rs1, tgt);
         else if (r < 82) mem[i] = mkI(6'h3F, 5'd0, 5'd0, 16'h0000);
         else             mem[i] = 32'h0000_0000;
         zf[i] = 1'($urandom_range(0, 1));
      end
   endtask

   // Instruction-level reference: program-order retire list and bubbles expected before each
   task automatic buildTrace();
      logic [15:0] pc;
      logic [31:0] w;
      logic [5:0]  op;
      bit          prevLd, prevTaken, taken;
      logic [4:0]  prevRd;
      pc = 16'd0; prevLd = 1'b0; prevTaken = 1'b0; prevRd = 5'd0;
      trLen = 0;
      for (int k = 0; k < MAX_TR; k++) begin
         w = mem[pc[5:0]];
         trIns[k] = w;
         trPc[k]  = pc;
         trBub[k] = (prevTaken || (prevLd && (prevRd != 5'd0) && readsReg(w, prevRd))) ? 1 : 0;
         trLen    = k + 1;
         op = w[31:26];
         if (op == 6'h3F) break;
         taken = (op == 6'h20) || ((op == 6'h21) && zf[pc[5:0]]) || ((op == 6'h22) && !zf[pc[5:0]]);
         prevTaken = taken;
         prevLd    = (op == 6'h10);
         prevRd    = w[25:21];
         pc = taken ? w[15:0] : pc + 16'd1;
      end
   endtask

   // Closed loop: the bench plays the PC / fetch register, the DUT steers it
   task automatic runProgram(input int progNum);
      logic [15:0] pc;
      logic [31:0] nIns;
      logic [15:0] nAddr;
      int idx, bub;
      rst_n    = 1'b0;
      ins      = mem[0];
      curAddr  = 16'd0;
      zeroFlag = zf[0];
      pc       = 16'd1;
      nIns     = mem[0];
      nAddr    = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      idx = 0;
      bub = 0;
      for (int cyc = 0; cyc < CYC_MAX && idx < trLen; cyc++) begin
         if (decValid) begin
            checkOutput($sformatf("rnd%0d_dec_ins[%0d]", progNum, idx), decIns, trIns[idx]);
            checkOutput($sformatf("rnd%0d_dec_pc[%0d]", progNum, idx), 32'(decPc), 32'(trPc[idx]));
            if (idx > 0)
               checkOutput($sformatf("rnd%0d_bubbles[%0d]", progNum, idx), 32'(bub), 32'(trBub[idx]));
            if (trIns[idx][31:26] == 6'h3F)
               checkOutput($sformatf("rnd%0d_halted", progNum), 32'(halted), 32'h1);
            idx++;
            bub = 0;
         end else begin
            bub++;
         end
         if (!stallPm) begin
            nIns  = mem[pc[5:0]];
            nAddr = pc;
         end
         if (!stall) pc = pcSel ? jmpLoc : pc + 16'd1;
         @(posedge clk);
         #1;
         ins      = nIns;
         curAddr  = nAddr;
         zeroFlag = zf[nAddr[5:0]];
         @(negedge clk);
      end
      checkOutput($sformatf("rnd%0d_progress", progNum), 32'(idx), 32'(trLen));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      logic [31:0] jmpIns, wrongIns, bzIns, xIns, yIns, ldIns, addIns, hltIns, nopIns;
      nopIns = 32'h0000_0000;

      // Reset state
      rst_n = 1'b0; ins = nopIns; curAddr = 16'd0; zeroFlag = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_pc_mux_sel", 32'(pcSel), 32'h0);
      checkOutput("rst_stall", 32'(stall), 32'h0);
      checkOutput("rst_stall_pm", 32'(stallPm), 32'h0);
      checkOutput("rst_jmp_loc", 32'(jmpLoc), 32'h0);
      checkOutput("rst_dec_valid", 32'(decValid), 32'h0);
      checkOutput("rst_dec_ins", decIns, 32'h0);
      checkOutput("rst_dec_pc", 32'(decPc), 32'h0);
      checkOutput("rst_halted", 32'(halted), 32'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_dec_valid_0", 32'(decValid), 32'h0);
      applyStimulus(nopIns, 16'd1, 1'b0);
      checkOutput("rel_dec_valid_1", 32'(decValid), 32'h1);
      checkOutput("rel_dec_pc", 32'(decPc), 32'h0);
      checkOutput("rel_stall", 32'(stall), 32'h0);

      // JMP redirect with exactly one squashed slot
      jmpIns   = mkI(6'h20, 5'd0, 5'd0, 16'h0008);
      wrongIns = mkR(6'h01, 5'd9, 5'd10, 5'd11);
      xIns     = mkR(6'h02, 5'd1, 5'd2, 5'd3);
      applyStimulus(jmpIns, 16'd3, 1'b0);
      checkOutput("jmp_pc_mux_sel", 32'(pcSel), 32'h1);
      checkOutput("jmp_jmp_loc", 32'(jmpLoc), 32'h8);
      checkOutput("jmp_stall", 32'(stall), 32'h0);
      applyStimulus(wrongIns, 16'd4, 1'b0);
      checkOutput("jmp_dec_ins", decIns, jmpIns);
      checkOutput("jmp_dec_pc", 32'(decPc), 32'h3);
      checkOutput("jmp_dec_valid", 32'(decValid), 32'h1);
      checkOutput("flush_pc_mux_sel", 32'(pcSel), 32'h0);
      applyStimulus(xIns, 16'd8, 1'b0);
      checkOutput("flush_dec_valid", 32'(decValid), 32'h0);
      applyStimulus(nopIns, 16'd9, 1'b0);
      checkOutput("jmp_target_dec_ins", decIns, xIns);
      checkOutput("jmp_target_dec_pc", 32'(decPc), 32'h8);
      checkOutput("jmp_target_valid", 32'(decValid), 32'h1);

      // BZ taken, then BZ not taken
      bzIns = mkI(6'h21, 5'd0, 5'd0, 16'h0020);
      yIns  = mkR(6'h03, 5'd4, 5'd6, 5'd7);
      applyStimulus(bzIns, 16'd10, 1'b1);
      checkOutput("bz_t_pc_mux_sel", 32'(pcSel), 32'h1);
      checkOutput("bz_t_jmp_loc", 32'(jmpLoc), 32'h20);
      applyStimulus(wrongIns, 16'd11, 1'b0);
      checkOutput("bz_t_dec_ins", decIns, bzIns);
      applyStimulus(xIns, 16'h20, 1'b0);
      checkOutput("bz_t_squash", 32'(decValid), 32'h0);
      applyStimulus(bzIns, 16'h21, 1'b0);
      checkOutput("bz_t_target", decIns, xIns);
      checkOutput("bz_n_pc_mux_sel", 32'(pcSel), 32'h0);
      checkOutput("bz_n_stall", 32'(stall), 32'h0);
      applyStimulus(yIns, 16'h22, 1'b0);
      checkOutput("bz_n_dec_ins", decIns, bzIns);
      applyStimulus(nopIns, 16'h23, 1'b0);
      checkOutput("bz_n_no_bubble_valid", 32'(decValid), 32'h1);
      checkOutput("bz_n_no_bubble_ins", decIns, yIns);

      // Load-use bubble, then the r0 exemption
      ldIns  = mkI(6'h10, 5'd5, 5'd1, 16'h0000);
      addIns = mkR(6'h01, 5'd6, 5'd5, 5'd2);
      applyStimulus(ldIns, 16'h30, 1'b0);
      checkOutput("ld_stall", 32'(stall), 32'h0);
      applyStimulus(addIns, 16'h31, 1'b0);
      checkOutput("lu_stall", 32'(stall), 32'h1);
      checkOutput("lu_stall_pm", 32'(stallPm), 32'h1);
      checkOutput("lu_dec_ld", decIns, ldIns);
      applyStimulus(addIns, 16'h31, 1'b0);
      checkOutput("lu_release_stall", 32'(stall), 32'h0);
      checkOutput("lu_bubble", 32'(decValid), 32'h0);
      applyStimulus(nopIns, 16'h32, 1'b0);
      checkOutput("lu_add_ins", decIns, addIns);
      checkOutput("lu_add_pc", 32'(decPc), 32'h31);
      applyStimulus(nopIns, 16'h33, 1'b0);
      checkOutput("lu_add_once", 32'(decPc), 32'h32);
      ldIns  = mkI(6'h10, 5'd0, 5'd1, 16'h0000);
      addIns = mkR(6'h01, 5'd6, 5'd0, 5'd2);
      applyStimulus(ldIns, 16'h40, 1'b0);
      applyStimulus(addIns, 16'h41, 1'b0);
      checkOutput("r0_no_stall", 32'(stall), 32'h0);
      applyStimulus(nopIns, 16'h42, 1'b0);
      checkOutput("r0_add_issued", decIns, addIns);

      // Reset while in LDSTALL
      ldIns  = mkI(6'h10, 5'd3, 5'd1, 16'h0000);
      addIns = mkR(6'h01, 5'd6, 5'd3, 5'd2);
      applyStimulus(ldIns, 16'h50, 1'b0);
      applyStimulus(addIns, 16'h51, 1'b0);
      checkOutput("rl_pre_stall", 32'(stall), 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rl_async_dec_pc", 32'(decPc), 32'h0);
      checkOutput("rl_async_dec_valid", 32'(decValid), 32'h0);
      checkOutput("rl_async_stall", 32'(stall), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rl_no_stale_stall", 32'(stall), 32'h0);
      applyStimulus(nopIns, 16'h52, 1'b0);
      checkOutput("rl_add_issued", decIns, addIns);
      checkOutput("rl_add_valid", 32'(decValid), 32'h1);

      // Reset while in FLUSH
      jmpIns = mkI(6'h20, 5'd0, 5'd0, 16'h0060);
      applyStimulus(jmpIns, 16'h53, 1'b0);
      checkOutput("rf_pc_mux_sel", 32'(pcSel), 32'h1);
      @(posedge clk);
      #1;
      ins = wrongIns; curAddr = 16'h54;
      rst_n = 1'b0;
      #1;
      checkOutput("rf_async_dec_valid", 32'(decValid), 32'h0);
      checkOutput("rf_async_dec_ins", decIns, 32'h0);
      checkOutput("rf_async_dec_pc", 32'(decPc), 32'h0);
      @(negedge clk);
      ins = xIns; curAddr = 16'h60;
      rst_n = 1'b1;
      #1;
      applyStimulus(nopIns, 16'h61, 1'b0);
      checkOutput("rf_no_stale_bubble", 32'(decValid), 32'h1);
      checkOutput("rf_first_ins", decIns, xIns);

      // HLT then sticky halt
      hltIns = mkI(6'h3F, 5'd0, 5'd0, 16'h0000);
      applyStimulus(hltIns, 16'd12, 1'b0);
      checkOutput("hlt_stall", 32'(stall), 32'h1);
      checkOutput("hlt_stall_pm", 32'(stallPm), 32'h1);
      checkOutput("hlt_pc_mux_sel", 32'(pcSel), 32'h0);
      checkOutput("hlt_halted_pre", 32'(halted), 32'h0);
      for (int i = 0; i < 21; i++) begin
         applyStimulus(hltIns, 16'd12, 1'b0);
         checkOutput("halt_halted", 32'(halted), 32'h1);
         checkOutput("halt_stall", 32'(stall), 32'h1);
         checkOutput("halt_stall_pm", 32'(stallPm), 32'h1);
         checkOutput("halt_dec_valid", 32'(decValid), (i == 0) ? 32'h1 : 32'h0);
      end
      rst_n = 1'b0;
      #1;
      checkOutput("halt_rst_halted", 32'(halted), 32'h0);
      checkOutput("halt_rst_stall", 32'(stall), 32'h0);
      @(negedge clk);
      ins = nopIns; curAddr = 16'd0;
      rst_n = 1'b1;
      #1;
      checkOutput("halt_rel_stall", 32'(stall), 32'h0);

      // Random programs against the instruction-level trace
      for (int p = 0; p < 4; p++) begin
         genProgram();
         buildTrace();
         runProgram(p);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
